// File: rtl/cdb_arbiter.sv
// CDB completion arbiter: one holding register per functional-unit lane, a
// round-robin grant, and the CDB broadcast plus RS slot release for the winner.
package cdb_arbiter_pkg;
  localparam int RS_IDX_W = 3;

  typedef struct packed {
    logic [RS_IDX_W-1:0] remove_idx;
    logic                remove_en;
  } EX_RS_PACKET;
endpackage

module cdb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int PREG_W = 6,
  parameter int IDX_W  = cdb_arbiter_pkg::RS_IDX_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       interrupt,
  input  logic [NUM_FU-1:0]          fu_done,
  input  logic [NUM_FU*PREG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0]          fu_has_dest,
  input  logic [NUM_FU*IDX_W-1:0]    fu_rs_idx,
  output logic [NUM_FU-1:0]          fu_stall,
  output logic [PREG_W-1:0]          cdb,
  output logic                       cdb_en,
  output cdb_arbiter_pkg::EX_RS_PACKET ex_rs_packet
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] r_hold_valid;
  logic [NUM_FU-1:0] r_hold_dest;
  logic [PREG_W-1:0] r_hold_tag [NUM_FU];
  logic [IDX_W-1:0]  r_hold_idx [NUM_FU];
  logic [PTR_W-1:0]  r_rr_ptr;

  logic              w_gnt_valid;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [NUM_FU-1:0] w_gnt_lane;
  logic              w_flush;

  assign w_flush = reset | interrupt;

  // Round-robin scan from r_rr_ptr; depends on flops only, so no input reaches an output.
  always_comb begin : grant_scan
    logic [PTR_W:0] w_sum;
    logic [PTR_W-1:0] w_lane;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_sum       = '0;
    w_lane      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_sum  = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      w_lane = (w_sum >= (PTR_W+1)'(NUM_FU)) ? PTR_W'(w_sum - (PTR_W+1)'(NUM_FU))
                                             : PTR_W'(w_sum);
      if (!w_gnt_valid && r_hold_valid[w_lane]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_lane;
      end else begin
        w_gnt_valid = w_gnt_valid;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_lane
      assign w_gnt_lane[gi] = w_gnt_valid && (w_gnt_idx == PTR_W'(gi));
      assign fu_stall[gi]   = r_hold_valid[gi] & ~w_gnt_lane[gi];

      // A granted lane may refill in the same edge; a stalled lane ignores its inputs.
      always_ff @(posedge clock) begin
        if (w_flush) begin
          r_hold_valid[gi] <= 1'b0;
          r_hold_dest[gi]  <= 1'b0;
          r_hold_tag[gi]   <= '0;
          r_hold_idx[gi]   <= '0;
        end else if (fu_done[gi] && !fu_stall[gi]) begin
          r_hold_valid[gi] <= 1'b1;
          r_hold_dest[gi]  <= fu_has_dest[gi];
          r_hold_tag[gi]   <= fu_tag[gi*PREG_W +: PREG_W];
          r_hold_idx[gi]   <= fu_rs_idx[gi*IDX_W +: IDX_W];
        end else if (w_gnt_lane[gi]) begin
          r_hold_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Pointer moves just past the winner so every lane waits at most NUM_FU-1 cycles.
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_valid) begin
      r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_FU-1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end
  end

  assign cdb_en                  = w_gnt_valid & r_hold_dest[w_gnt_idx];
  assign cdb                     = cdb_en ? r_hold_tag[w_gnt_idx] : '0;
  assign ex_rs_packet.remove_en  = w_gnt_valid;
  assign ex_rs_packet.remove_idx = w_gnt_valid ? r_hold_idx[w_gnt_idx] : '0;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter: expected grants are queued as stimulus is
// driven and compared in order whenever the arbiter releases an RS slot.
module tb_cdb_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        interrupt;
  logic [4:0]  fu_done;
  logic [29:0] fu_tag;
  logic [4:0]  fu_has_dest;
  logic [14:0] fu_rs_idx;
  logic [4:0]  fu_stall;
  logic [5:0]  cdb;
  logic        cdb_en;
  cdb_arbiter_pkg::EX_RS_PACKET ex_rs_packet;

  typedef struct packed {
    logic       en;
    logic [5:0] tag;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t obs;
  int   n_checks = 0;
  int   n_fail   = 0;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .interrupt(interrupt),
    .fu_done(fu_done), .fu_tag(fu_tag), .fu_has_dest(fu_has_dest),
    .fu_rs_idx(fu_rs_idx), .fu_stall(fu_stall), .cdb(cdb), .cdb_en(cdb_en),
    .ex_rs_packet(ex_rs_packet)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fu_done = 5'd0; fu_tag = 30'd0; fu_has_dest = 5'd0; fu_rs_idx = 15'd0;
  endtask

  // Drive one lane's completion and queue the packet the arbiter must produce for it.
  task automatic drive_lane(input int lane, input logic [5:0] tag, input logic dest,
                            input logic [2:0] idx, input bit expect_it);
    exp_t x;
    fu_done[lane]           = 1'b1;
    fu_tag[lane*6 +: 6]     = tag;
    fu_has_dest[lane]       = dest;
    fu_rs_idx[lane*3 +: 3]  = idx;
    x.en  = dest;
    x.tag = dest ? tag : 6'd0;
    x.idx = idx;
    if (expect_it) sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b1; interrupt = 1'b0; clear_inputs();
    fu_done = 5'b11111; fu_has_dest = 5'b11111; fu_tag = 30'h3FFF_FFFF;
    tick(); tick();
    reset = 1'b0; clear_inputs();
    n_checks++; if (fu_stall !== 5'd0) begin n_fail++; $display("FAIL reset_stall got %b want 00000", fu_stall); end
    n_checks++; if (cdb_en !== 1'b0) begin n_fail++; $display("FAIL reset_cdb_en got %b want 0", cdb_en); end
    n_checks++; if (cdb !== 6'd0) begin n_fail++; $display("FAIL reset_cdb got %0d want 0", cdb); end
    n_checks++; if (ex_rs_packet.remove_en !== 1'b0) begin n_fail++; $display("FAIL reset_remove_en got %b want 0", ex_rs_packet.remove_en); end
    n_checks++; if (ex_rs_packet.remove_idx !== 3'd0) begin n_fail++; $display("FAIL reset_remove_idx got %0d want 0", ex_rs_packet.remove_idx); end
    n_checks++; if (dut.r_rr_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_rr_ptr got %0d want 0", dut.r_rr_ptr); end
  endtask

  task automatic test_single_alu();
    drive_lane(0, 6'd12, 1'b1, 3'd0, 1'b1);
    tick(); clear_inputs();
    n_checks++; if (ex_rs_packet.remove_en !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL alu_grant remove_en %b queued %0d want 1", ex_rs_packet.remove_en, sb.size());
    end else begin
      e = sb.pop_front(); obs = {cdb_en, cdb, ex_rs_packet.remove_idx};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL alu_packet got en=%b tag=%0d idx=%0d want en=%b tag=%0d idx=%0d", obs.en, obs.tag, obs.idx, e.en, e.tag, e.idx); end
    end
    tick();
    n_checks++; if ({cdb_en, cdb, ex_rs_packet} !== 11'd0 || fu_stall !== 5'd0) begin
      n_fail++; $display("FAIL alu_idle got cdb_en=%b cdb=%0d pkt=%h stall=%b want all 0", cdb_en, cdb, ex_rs_packet, fu_stall);
    end
  endtask

  task automatic test_store();
    drive_lane(2, 6'd33, 1'b0, 3'd2, 1'b1);
    tick(); clear_inputs();
    n_checks++; if (ex_rs_packet.remove_en !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL store_grant remove_en %b queued %0d want 1", ex_rs_packet.remove_en, sb.size());
    end else begin
      e = sb.pop_front(); obs = {cdb_en, cdb, ex_rs_packet.remove_idx};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL store_packet got en=%b tag=%0d idx=%0d want en=%b tag=%0d idx=%0d", obs.en, obs.tag, obs.idx, e.en, e.tag, e.idx); end
    end
    tick();
    n_checks++; if (ex_rs_packet.remove_en !== 1'b0) begin n_fail++; $display("FAIL store_idle remove_en got %b want 0", ex_rs_packet.remove_en); end
  endtask

  task automatic test_contention();
    logic [4:0] want_stall [3];
    want_stall[0] = 5'b11000; want_stall[1] = 5'b10000; want_stall[2] = 5'b00000;
    reset = 1'b1; tick(); reset = 1'b0;
    drive_lane(1, 6'd5, 1'b1, 3'd1, 1'b1);
    drive_lane(3, 6'd9, 1'b1, 3'd3, 1'b1);
    drive_lane(4, 6'd20, 1'b1, 3'd4, 1'b1);
    tick(); clear_inputs();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (fu_stall !== want_stall[c]) begin n_fail++; $display("FAIL contention_stall c%0d got %b want %b", c, fu_stall, want_stall[c]); end
      n_checks++; if (ex_rs_packet.remove_en !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL contention_grant c%0d remove_en %b queued %0d want 1", c, ex_rs_packet.remove_en, sb.size());
      end else begin
        e = sb.pop_front(); obs = {cdb_en, cdb, ex_rs_packet.remove_idx};
        n_checks++; if (obs !== e) begin n_fail++; $display("FAIL contention_packet c%0d got en=%b tag=%0d idx=%0d want en=%b tag=%0d idx=%0d", c, obs.en, obs.tag, obs.idx, e.en, e.tag, e.idx); end
      end
      tick();
    end
    n_checks++; if (dut.r_rr_ptr !== 3'd0) begin n_fail++; $display("FAIL contention_rr_ptr got %0d want 0", dut.r_rr_ptr); end
    n_checks++; if (ex_rs_packet.remove_en !== 1'b0) begin n_fail++; $display("FAIL contention_drained remove_en got %b want 0", ex_rs_packet.remove_en); end
  endtask

  task automatic test_wrap();
    logic [2:0] want_ptr [3];
    logic [4:0] want_stall [3];
    want_ptr[0] = 3'd0; want_ptr[1] = 3'd4; want_ptr[2] = 3'd0;
    want_stall[0] = 5'b00000; want_stall[1] = 5'b00001; want_stall[2] = 5'b00000;
    drive_lane(3, 6'd7, 1'b1, 3'd3, 1'b1);
    tick(); clear_inputs();
    // Lane 3 wins this cycle and moves the pointer to 4 while lanes 0 and 4 load.
    drive_lane(0, 6'd2, 1'b1, 3'd0, 1'b0);
    drive_lane(4, 6'd40, 1'b1, 3'd4, 1'b1);
    drive_lane(0, 6'd2, 1'b1, 3'd0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (dut.r_rr_ptr !== want_ptr[c]) begin n_fail++; $display("FAIL wrap_rr_ptr c%0d got %0d want %0d", c, dut.r_rr_ptr, want_ptr[c]); end
      n_checks++; if (fu_stall !== want_stall[c]) begin n_fail++; $display("FAIL wrap_stall c%0d got %b want %b", c, fu_stall, want_stall[c]); end
      n_checks++; if (ex_rs_packet.remove_en !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL wrap_grant c%0d remove_en %b queued %0d want 1", c, ex_rs_packet.remove_en, sb.size());
      end else begin
        e = sb.pop_front(); obs = {cdb_en, cdb, ex_rs_packet.remove_idx};
        n_checks++; if (obs !== e) begin n_fail++; $display("FAIL wrap_packet c%0d got en=%b tag=%0d idx=%0d want en=%b tag=%0d idx=%0d", c, obs.en, obs.tag, obs.idx, e.en, e.tag, e.idx); end
      end
      tick(); clear_inputs();
    end
    n_checks++; if (dut.r_rr_ptr !== 3'd1) begin n_fail++; $display("FAIL wrap_final_ptr got %0d want 1", dut.r_rr_ptr); end
  endtask

  task automatic test_back_to_back();
    drive_lane(0, 6'd1, 1'b1, 3'd0, 1'b1);
    tick();
    for (int k = 2; k <= 5; k++) begin
      n_checks++; if (fu_stall[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_stall k%0d got 1 want 0", k); end
      n_checks++; if (ex_rs_packet.remove_en !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL b2b_grant k%0d remove_en %b queued %0d want 1", k, ex_rs_packet.remove_en, sb.size());
      end else begin
        e = sb.pop_front(); obs = {cdb_en, cdb, ex_rs_packet.remove_idx};
        n_checks++; if (obs !== e) begin n_fail++; $display("FAIL b2b_packet k%0d got en=%b tag=%0d idx=%0d want en=%b tag=%0d idx=%0d", k, obs.en, obs.tag, obs.idx, e.en, e.tag, e.idx); end
      end
      clear_inputs();
      if (k <= 4) drive_lane(0, 6'(k), 1'b1, 3'd0, 1'b1);
      tick();
    end
    n_checks++; if (ex_rs_packet.remove_en !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_drained remove_en %b queued %0d want 0/0", ex_rs_packet.remove_en, sb.size());
    end
  endtask

  task automatic test_interrupt();
    drive_lane(0, 6'd10, 1'b1, 3'd0, 1'b0);
    drive_lane(1, 6'd11, 1'b1, 3'd1, 1'b1);
    drive_lane(2, 6'd12, 1'b0, 3'd2, 1'b0);
    drive_lane(3, 6'd13, 1'b1, 3'd3, 1'b0);
    drive_lane(4, 6'd14, 1'b1, 3'd4, 1'b0);
    tick();
    // Pointer sits at 1 from the previous scenario, so lane 1 shows this cycle.
    n_checks++; if (ex_rs_packet.remove_en !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL int_pre_grant remove_en %b queued %0d want 1", ex_rs_packet.remove_en, sb.size());
    end else begin
      e = sb.pop_front(); obs = {cdb_en, cdb, ex_rs_packet.remove_idx};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL int_pre_packet got en=%b tag=%0d idx=%0d want en=%b tag=%0d idx=%0d", obs.en, obs.tag, obs.idx, e.en, e.tag, e.idx); end
    end
    n_checks++; if (fu_stall !== 5'b11101) begin n_fail++; $display("FAIL int_pre_stall got %b want 11101", fu_stall); end
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0; clear_inputs();
    n_checks++; if (cdb_en !== 1'b0 || ex_rs_packet.remove_en !== 1'b0) begin n_fail++; $display("FAIL int_flush_out got cdb_en=%b remove_en=%b want 0/0", cdb_en, ex_rs_packet.remove_en); end
    n_checks++; if (fu_stall !== 5'd0) begin n_fail++; $display("FAIL int_flush_stall got %b want 00000", fu_stall); end
    n_checks++; if (dut.r_rr_ptr !== 3'd0) begin n_fail++; $display("FAIL int_flush_rr_ptr got %0d want 0", dut.r_rr_ptr); end
    drive_lane(3, 6'd17, 1'b1, 3'd3, 1'b1);
    tick(); clear_inputs();
    n_checks++; if (ex_rs_packet.remove_en !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL int_post_grant remove_en %b queued %0d want 1", ex_rs_packet.remove_en, sb.size());
    end else begin
      e = sb.pop_front(); obs = {cdb_en, cdb, ex_rs_packet.remove_idx};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL int_post_packet got en=%b tag=%0d idx=%0d want en=%b tag=%0d idx=%0d", obs.en, obs.tag, obs.idx, e.en, e.tag, e.idx); end
    end
    tick();
    n_checks++; if (ex_rs_packet.remove_en !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL int_drained remove_en %b queued %0d want 0/0", ex_rs_packet.remove_en, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_store();
    test_contention();
    test_wrap();
    test_back_to_back();
    test_interrupt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-side counterpart to the reservation station: collects finished results from the five functional-unit lanes (one per RS slot), selects one per cycle, and drives the CDB tag broadcast (`cdb`/`cdb_en`) plus the RS slot release (`ex_rs_packet`) that frees the issuing entry. It sits between the execute-stage functional units and the RS, map table and ROB wakeup logic. Each lane has a one-entry holding register, so a unit that loses arbitration is stalled rather than dropped.

## Interface
- `NUM_FU`, default 5: lanes; lane i is RS slot i (0 ALU, 1 load, 2 store, 3/4 mult).
- `PREG_W`, default 6: physical register tag width.
- `IDX_W`, default 3: RS index width.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `interrupt`  in  1  synchronous flush, same effect as reset on all state.
- `fu_done`  in  NUM_FU  lane i has a completed result this cycle.
- `fu_tag`  in  NUM_FU×PREG_W  destination physical register per lane.
- `fu_has_dest`  in  NUM_FU  lane result writes a register (0 for stores and rd==x0).
- `fu_rs_idx`  in  NUM_FU×IDX_W  RS slot that issued the instruction.
- `fu_stall`  out  NUM_FU  lane i must hold `fu_done` and its data stable.
- `cdb`  out  PREG_W  broadcast tag (`TAG.phys_reg`).
- `cdb_en`  out  1  broadcast valid.
- `ex_rs_packet`  out  `EX_RS_PACKET`  `remove_idx` plus `remove_en`.

## Operation
- Per-lane state: `hold_valid`, `hold_tag`, `hold_dest`, `hold_idx`. Also a round-robin pointer `rr_ptr` (range 0..NUM_FU-1).
- Grant (combinational from flops only): scan lanes `rr_ptr`, `rr_ptr+1`, … modulo NUM_FU. The grant goes to the first lane with `hold_valid`=1. At most one grant per cycle.
- Outputs when lane g is granted:
  - `remove_en`=1, `remove_idx`=`hold_idx[g]`.
  - `cdb_en`=`hold_dest[g]`, `cdb`=`hold_tag[g]` if `hold_dest[g]`, else 0.
- Outputs with no grant: `cdb_en`=0, `remove_en`=0, `cdb`=0, `remove_idx`=0.
- Store lanes (`hold_dest`=0) consume a grant slot: they release their RS entry without a CDB broadcast.
- `fu_stall[i]` = `hold_valid[i]` && (no grant or grant≠i).
- Capture at clock edge:
  - Lane i loads its inputs when `fu_done[i]` && !`fu_stall[i]`.
  - So a granted lane refills in the same cycle.
  - If the lane is granted and `fu_done[i]`=0, `hold_valid[i]` clears.
  - If the lane is stalled, its inputs are ignored and the holding register is unchanged.
- Pointer update: after a grant to lane g, `rr_ptr` ← (g+1) mod NUM_FU, so 4 wraps to 0. No grant leaves `rr_ptr` unchanged.
- Reset/interrupt clear all `hold_valid`, `hold_*` fields and `rr_ptr`. Interrupt has priority over any same-cycle `fu_done` capture.
- No combinational path from any input to any output.

## Timing
- Latency: `fu_done` sampled at edge of cycle N → `cdb_en`/`remove_en` in cycle N+1 at earliest. The RS sees `cdb` in N+1 and updates `ready` at the edge ending N+1.
- Throughput: one completion per cycle sustained. A lane granted every cycle never stalls.
- Contention: k valid lanes drain in exactly k cycles. Worst-case wait for any lane is NUM_FU-1 cycles (starvation-free).
- Reset values: `fu_stall`=0, `cdb_en`=0, `cdb`=0, `remove_en`=0, `remove_idx`=0, `rr_ptr`=0.
- Reset or interrupt mid-contention: every held result is discarded. Outputs are 0 in the following cycle even if `fu_done` was high at the flush edge.
- Simultaneous grant and refill on one lane: the new data is presented the next cycle with no bubble.

## Test plan
- Single ALU result:
  - Stimulus: lane 0 `fu_done`, tag 12, dest 1, idx 0 in cycle 1.
  - Required: cycle 2 `cdb_en`=1, `cdb`=12, `remove_en`=1, `remove_idx`=0; cycle 3 all outputs 0.
- Store without dest:
  - Stimulus: lane 2 done, dest 0, idx 2.
  - Required: next cycle `remove_en`=1, `remove_idx`=2, `cdb_en`=0, `cdb`=0.
- Three-way contention:
  - Stimulus: lanes 1, 3, 4 done in cycle 1 (tags 5, 9, 20), `rr_ptr`=0.
  - Required: grants in order 1, 3, 4 in cycles 2, 3, 4.
  - Required: `fu_stall` = 5'b11000 in cycle 2 and 5'b10000 in cycle 3; `rr_ptr`=0 after cycle 4.
- Wrap-around fairness:
  - Stimulus: `rr_ptr`=4, lanes 0 and 4 both valid.
  - Required: lane 4 granted first, then lane 0; pointer goes 4→0→1.
- Back-to-back refill:
  - Stimulus: lane 0 done every cycle for 4 cycles, tags 1..4, no other lanes.
  - Required: `cdb` 1, 2, 3, 4 on consecutive cycles; `fu_stall[0]` never asserted.
- Interrupt flush:
  - Stimulus: lanes 0..4 all held, assert `interrupt` for one cycle.
  - Required: next cycle `cdb_en`=0, `remove_en`=0, `fu_stall`=0, `rr_ptr`=0; a new lane 3 done afterwards is broadcast 1 cycle later.
